// File: rtl/minesweeper_solver_core.sv
// ---------------------------------------------------------------------------
// minesweeper_solver_core
//
// Purpose:
//   Applies the two basic Minesweeper deductions to a board held in an
//   internal ROWS x COLS array of 4-bit cell codes. For every revealed cell
//   (code 0-8) the core counts its hidden (E) and flagged (F) neighbours.
//   - flags == value and hidden > 0         : every hidden neighbour is safe
//   - hidden + flags == value, hidden > 0   : every hidden neighbour is a mine
//   Each resulting action is offered on a valid/ready port. Accepted actions
//   update the board: F for a flag, D (pending reveal) for a reveal. Passes
//   repeat while they keep producing actions, up to MAX_PASS passes.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_reset       synchronous active-low reset
//   i_start       pulse, begins a solve run when idle
//   i_step        pulse, advances one cell in single-step mode
//   i_step_mode   1 = single-step, 0 = free-run (sampled with i_start)
//   i_ld_en       board write strobe (honoured only while idle)
//   i_ld_addr     board write address, row*COLS+col
//   i_ld_data     cell code: 0-8 count, D pending-reveal, E hidden, F flagged
//   o_act_valid   action available
//   i_act_ready   consumer accepts the action
//   o_act_addr    target cell of the action
//   o_act_flag    1 = flag the cell, 0 = reveal it
//   o_busy        high from start acceptance until the run ends
//   o_done        one-cycle pulse at run end
//   o_progress    last run emitted at least one action
//   o_pass_cnt    passes completed by the last run
// ---------------------------------------------------------------------------
module minesweeper_solver_core #(
  parameter  int ROWS     = 8,
  parameter  int COLS     = 8,
  parameter  int MAX_PASS = 15,
  localparam int N        = ROWS * COLS,
  localparam int AW       = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_step,
  input  logic          i_step_mode,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [3:0]    i_ld_data,
  output logic          o_act_valid,
  input  logic          i_act_ready,
  output logic [AW-1:0] o_act_addr,
  output logic          o_act_flag,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_progress,
  output logic [7:0]    o_pass_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    NEIGH,
    DECIDE,
    EMIT,
    WAIT_STEP,
    DONE
  } stateT;

  localparam logic [AW-1:0]       LAST_CELL  = AW'(N - 1);
  localparam logic [AW:0]         N_EXT      = (AW + 1)'(N);
  localparam logic [5:0]          LAST_COL   = 6'(COLS - 1);
  localparam logic signed [11:0]  ROWS_S     = 12'(ROWS);
  localparam logic signed [11:0]  COLS_S     = 12'(COLS);
  localparam logic [7:0]          MAX_PASS_U = 8'(MAX_PASS);

  localparam logic [3:0] CODE_PEND   = 4'hD;
  localparam logic [3:0] CODE_HIDDEN = 4'hE;
  localparam logic [3:0] CODE_FLAG   = 4'hF;

  stateT r_state;
  stateT w_nextState;

  logic [3:0]    r_board [N];
  logic [AW-1:0] r_cell;
  logic [5:0]    r_row;
  logic [5:0]    r_col;
  logic [2:0]    r_dir;
  logic [3:0]    r_hCnt;
  logic [3:0]    r_fCnt;
  logic          r_isFlag;
  logic          r_stepMode;
  logic          r_passAct;
  logic          r_progress;
  logic [7:0]    r_passCnt;

  logic signed [11:0] w_dRow;
  logic signed [11:0] w_dCol;
  logic signed [11:0] w_nbrRow;
  logic signed [11:0] w_nbrCol;
  logic               w_onBoard;
  logic [AW-1:0]      w_nbrAddr;
  logic [3:0]         w_nbrCode;

  logic [3:0] w_cellCode;
  logic       w_informative;
  logic [4:0] w_hfSum;
  logic       w_revealOk;
  logic       w_flagOk;
  logic       w_emitHit;
  logic       w_accept;
  logic       w_dirLast;
  logic       w_lastCell;
  logic       w_passActNow;
  logic       w_morePasses;
  logic       w_cellDone;
  logic       w_advance;

  // Neighbour under the current direction. The walk order is fixed
  // (NW, N, NE, W, E, SW, S, SE) so that actions come out in a
  // predictable order. Off-board neighbours are mapped to address 0 so
  // the board is never indexed out of range; w_onBoard masks them.
  always_comb begin
    w_dRow = 12'sd0;
    w_dCol = 12'sd0;
    case (r_dir)
      3'd0:    begin w_dRow = -12'sd1; w_dCol = -12'sd1; end
      3'd1:    begin w_dRow = -12'sd1; w_dCol =  12'sd0; end
      3'd2:    begin w_dRow = -12'sd1; w_dCol =  12'sd1; end
      3'd3:    begin w_dRow =  12'sd0; w_dCol = -12'sd1; end
      3'd4:    begin w_dRow =  12'sd0; w_dCol =  12'sd1; end
      3'd5:    begin w_dRow =  12'sd1; w_dCol = -12'sd1; end
      3'd6:    begin w_dRow =  12'sd1; w_dCol =  12'sd0; end
      default: begin w_dRow =  12'sd1; w_dCol =  12'sd1; end
    endcase
    w_nbrRow  = $signed({6'd0, r_row}) + w_dRow;
    w_nbrCol  = $signed({6'd0, r_col}) + w_dCol;
    w_onBoard = (w_nbrRow >= 12'sd0) && (w_nbrRow < ROWS_S) &&
                (w_nbrCol >= 12'sd0) && (w_nbrCol < COLS_S);
    w_nbrAddr = w_onBoard ? AW'(w_nbrRow * COLS_S + w_nbrCol) : '0;
    w_nbrCode = r_board[w_nbrAddr];
  end

  assign w_cellCode    = r_board[r_cell];
  assign w_informative = (w_cellCode <= 4'd8);
  assign w_hfSum       = {1'b0, r_hCnt} + {1'b0, r_fCnt};
  assign w_revealOk    = (r_fCnt == w_cellCode) && (r_hCnt != 4'd0);
  assign w_flagOk      = (w_hfSum == {1'b0, w_cellCode}) && (r_hCnt != 4'd0);
  assign w_emitHit     = (r_state == EMIT) && w_onBoard && (w_nbrCode == CODE_HIDDEN);
  assign w_accept      = w_emitHit && i_act_ready;
  assign w_dirLast     = (r_dir == 3'd7);
  assign w_lastCell    = (r_cell == LAST_CELL);
  // An accept on the very last direction of the last cell must still count
  // toward "this pass did something", hence the bypass around r_passAct.
  assign w_passActNow  = r_passAct || w_accept;
  assign w_morePasses  = w_passActNow && ((r_passCnt + 8'd1) < MAX_PASS_U);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A cell "finishes" in SCAN (non-informative), DECIDE
  // (no rule fires) or EMIT (last direction handled). In single-step mode a
  // finished cell parks in WAIT_STEP and the step pulse performs the advance;
  // otherwise the advance happens in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_cellDone  = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_nextState = SCAN;
      end
      SCAN: begin
        if (w_informative) w_nextState = NEIGH;
        else               w_cellDone  = 1'b1;
      end
      NEIGH: begin
        if (w_dirLast) w_nextState = DECIDE;
      end
      DECIDE: begin
        if (w_revealOk || w_flagOk) w_nextState = EMIT;
        else                        w_cellDone  = 1'b1;
      end
      EMIT: begin
        if (w_dirLast && (!w_emitHit || w_accept)) w_cellDone = 1'b1;
      end
      WAIT_STEP: begin
        if (i_step) w_advance = 1'b1;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_cellDone) begin
      if (r_stepMode) w_nextState = WAIT_STEP;
      else            w_advance   = 1'b1;
    end
    if (w_advance) begin
      w_nextState = (w_lastCell && !w_morePasses) ? DONE : SCAN;
    end
  end

  // Solver datapath: cell/row/col position, direction walker, neighbour
  // counters and run statistics. Row and column are tracked alongside the
  // linear address so no divider is needed to locate neighbours.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cell     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_dir      <= '0;
      r_hCnt     <= '0;
      r_fCnt     <= '0;
      r_isFlag   <= 1'b0;
      r_stepMode <= 1'b0;
      r_passAct  <= 1'b0;
      r_progress <= 1'b0;
      r_passCnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cell     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_dir      <= '0;
            r_passCnt  <= '0;
            r_progress <= 1'b0;
            r_passAct  <= 1'b0;
            r_stepMode <= i_step_mode;
          end
        end
        SCAN: begin
          if (w_informative) begin
            r_dir  <= '0;
            r_hCnt <= '0;
            r_fCnt <= '0;
          end
        end
        NEIGH: begin
          if (w_onBoard && (w_nbrCode == CODE_HIDDEN)) r_hCnt <= r_hCnt + 4'd1;
          if (w_onBoard && (w_nbrCode == CODE_FLAG))   r_fCnt <= r_fCnt + 4'd1;
          r_dir <= r_dir + 3'd1;
        end
        DECIDE: begin
          // Reveal wins when both rules could fire.
          r_isFlag <= !w_revealOk;
        end
        EMIT: begin
          // Hold the direction while an action waits for the consumer.
          if (!w_emitHit || w_accept) r_dir <= r_dir + 3'd1;
          if (w_accept) begin
            r_passAct  <= 1'b1;
            r_progress <= 1'b1;
          end
        end
        default: begin
        end
      endcase
      if (w_advance) begin
        if (w_lastCell) begin
          r_passCnt <= r_passCnt + 8'd1;
          r_passAct <= 1'b0;
          r_cell    <= '0;
          r_row     <= '0;
          r_col     <= '0;
        end else begin
          r_cell <= r_cell + 1'b1;
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + 6'd1;
          end else begin
            r_col <= r_col + 6'd1;
          end
        end
      end
    end
  end

  // Board storage. External loads are only honoured while idle so a running
  // solve sees a stable board; accepted actions write back F or D.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < N; i++) r_board[i] <= CODE_HIDDEN;
    end else if ((r_state == IDLE) && i_ld_en && ({1'b0, i_ld_addr} < N_EXT)) begin
      r_board[i_ld_addr] <= i_ld_data;
    end else if (w_accept) begin
      r_board[w_nbrAddr] <= r_isFlag ? CODE_FLAG : CODE_PEND;
    end
  end

  assign o_act_valid = w_emitHit;
  assign o_act_addr  = w_emitHit ? w_nbrAddr : '0;
  assign o_act_flag  = w_emitHit && r_isFlag;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);
  assign o_progress  = r_progress;
  assign o_pass_cnt  = r_passCnt;

endmodule

// File: tb/tb_minesweeper_solver_core.sv
// ---------------------------------------------------------------------------
// tb_minesweeper_solver_core
//
// Directed bench for a 3x3 solver. Each scenario pushes its expected actions
// and end-of-run statistics into queues; an independent monitor pops them
// whenever an action is accepted or done pulses.
// ---------------------------------------------------------------------------
module tb_minesweeper_solver_core;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int N    = ROWS * COLS;
  localparam int AW   = $clog2(N);

  typedef logic [3:0] boardT [N];

  typedef struct {
    logic [AW-1:0] addr;
    logic          flag;
  } actT;

  typedef struct {
    logic       progress;
    logic [7:0] passCnt;
  } doneT;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          stepMode = 1'b0;
  logic          ldEn = 1'b0;
  logic [AW-1:0] ldAddr = '0;
  logic [3:0]    ldData = '0;
  logic          actReady = 1'b1;
  logic          actValid;
  logic [AW-1:0] actAddr;
  logic          actFlag;
  logic          busy;
  logic          done;
  logic          progress;
  logic [7:0]    passCnt;

  actT  expActQ[$];
  doneT expDoneQ[$];
  actT  monAct;
  doneT monDone;

  int checkCnt = 0;
  int errCnt   = 0;

  minesweeper_solver_core #(
    .ROWS(ROWS),
    .COLS(COLS),
    .MAX_PASS(15)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_start(start),
    .i_step(step),
    .i_step_mode(stepMode),
    .i_ld_en(ldEn),
    .i_ld_addr(ldAddr),
    .i_ld_data(ldData),
    .o_act_valid(actValid),
    .i_act_ready(actReady),
    .o_act_addr(actAddr),
    .o_act_flag(actFlag),
    .o_busy(busy),
    .o_done(done),
    .o_progress(progress),
    .o_pass_cnt(passCnt)
  );

  always #5 clk = ~clk;

  // Comparison helper shared by the monitor and the stimulus thread.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushAct(input int addr, input logic flag);
    actT a;
    a.addr = AW'(addr);
    a.flag = flag;
    expActQ.push_back(a);
  endtask

  task automatic pushDone(input logic prog, input int passes);
    doneT d;
    d.progress = prog;
    d.passCnt  = 8'(passes);
    expDoneQ.push_back(d);
  endtask

  task automatic writeCell(input int addr, input logic [3:0] code);
    ldEn   = 1'b1;
    ldAddr = AW'(addr);
    ldData = code;
    tick();
    ldEn   = 1'b0;
  endtask

  task automatic loadBoard(input boardT b);
    for (int i = 0; i < N; i++) writeCell(i, b[i]);
  endtask

  // Pulses start for one cycle; returns one edge after the DUT sampled it.
  task automatic applyStimulus(input logic mode);
    stepMode = mode;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checkCnt++;
      errCnt++;
      $display("[TB] FAIL doneTimeout: got no done, expected done within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic waitValid(input int budget);
    logic seen;
    int   cycles;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (actValid) seen = 1'b1;
    end
    if (!seen) begin
      checkCnt++;
      errCnt++;
      $display("[TB] FAIL validTimeout: got no act_valid, expected one within %0d cycles", budget);
    end
    tick();
  endtask

  // Monitor: every accepted action must match the head of the expected
  // action queue, and every done pulse the head of the run-result queue.
  always @(negedge clk) begin
    if (reset) begin
      if (actValid && actReady) begin
        if (expActQ.size() == 0) begin
          checkCnt++;
          errCnt++;
          $display("[TB] FAIL unexpectedAction: got addr %0d flag %0d, expected none",
                   actAddr, actFlag);
        end else begin
          monAct = expActQ.pop_front();
          checkOutput("actAddr", 32'(actAddr), 32'(monAct.addr));
          checkOutput("actFlag", 32'(actFlag), 32'(monAct.flag));
        end
      end
      if (done) begin
        if (expDoneQ.size() == 0) begin
          checkCnt++;
          errCnt++;
          $display("[TB] FAIL unexpectedDone: got done, expected none");
        end else begin
          monDone = expDoneQ.pop_front();
          checkOutput("doneProgress", 32'(progress), 32'(monDone.progress));
          checkOutput("donePassCnt", 32'(passCnt), 32'(monDone.passCnt));
          checkOutput("doneLeftoverActions", 32'(expActQ.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    boardT revealBoard;
    boardT flagBoard;
    int    cycles;
    int    steps;
    logic  seen;

    for (int i = 0; i < N; i++) begin
      revealBoard[i] = 4'hE;
      flagBoard[i]   = 4'hE;
    end
    revealBoard[0] = 4'h0;
    flagBoard[0]   = 4'h3;

    // Reset state.
    reset = 1'b0;
    tick();
    tick();
    checkOutput("rstActValid", 32'(actValid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstProgress", 32'(progress), 32'd0);
    checkOutput("rstPassCnt", 32'(passCnt), 32'd0);
    checkOutput("rstActAddr", 32'(actAddr), 32'd0);
    checkOutput("rstActFlag", 32'(actFlag), 32'd0);
    reset = 1'b1;
    tick();

    // All hidden: one pass of N SCAN cycles, then DONE.
    $display("[TB] scenario: all hidden board");
    pushDone(1'b0, 1);
    applyStimulus(1'b0);
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    waitDone(200, cycles);
    checkOutput("allHiddenLatency", 32'(cycles), 32'(N + 1));
    checkOutput("busyAfterDone", 32'(busy), 32'd0);

    // Zero corner: reveals 1,3,4; a stray start mid-run must be ignored.
    $display("[TB] scenario: zero corner reveals");
    loadBoard(revealBoard);
    pushAct(1, 1'b0);
    pushAct(3, 1'b0);
    pushAct(4, 1'b0);
    pushDone(1'b1, 2);
    applyStimulus(1'b0);
    repeat (25) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(300, cycles);

    // Backpressure: first action held stable for 5 cycles, emitted once.
    $display("[TB] scenario: backpressure hold");
    loadBoard(revealBoard);
    actReady = 1'b0;
    pushAct(1, 1'b0);
    pushAct(3, 1'b0);
    pushAct(4, 1'b0);
    pushDone(1'b1, 2);
    applyStimulus(1'b0);
    waitValid(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("holdValid", 32'(actValid), 32'd1);
      checkOutput("holdAddr", 32'(actAddr), 32'd1);
      checkOutput("holdFlag", 32'(actFlag), 32'd0);
    end
    tick();
    actReady = 1'b1;
    waitDone(300, cycles);

    // Corner 3: flags 1,3,4. Then cell 2 = 2 sees two flags and one hidden
    // neighbour (5), which only resolves if 1 and 4 really hold F.
    $display("[TB] scenario: corner flags and readback");
    loadBoard(flagBoard);
    pushAct(1, 1'b1);
    pushAct(3, 1'b1);
    pushAct(4, 1'b1);
    pushDone(1'b1, 2);
    applyStimulus(1'b0);
    waitDone(300, cycles);
    writeCell(2, 4'h2);
    pushAct(5, 1'b0);
    pushDone(1'b1, 2);
    applyStimulus(1'b0);
    waitDone(300, cycles);

    // Single-step mode: stall after cell 0, then N steps per pass.
    $display("[TB] scenario: single-step mode");
    loadBoard(revealBoard);
    pushAct(1, 1'b0);
    pushAct(3, 1'b0);
    pushAct(4, 1'b0);
    pushDone(1'b1, 2);
    applyStimulus(1'b1);
    stepMode = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tick();
    checkOutput("stallNoDone", 32'(seen), 32'd0);
    checkOutput("stallBusy", 32'(busy), 32'd1);
    checkOutput("stallActionsOut", 32'(expActQ.size()), 32'd0);
    steps = 0;
    while (!seen && steps < 30) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      steps++;
      for (int c = 0; c < 25 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      tick();
    end
    checkOutput("stepsToDone", 32'(steps), 32'(2 * N));

    // Reset while an action is pending.
    $display("[TB] scenario: reset mid-emit");
    loadBoard(revealBoard);
    actReady = 1'b0;
    pushAct(1, 1'b0);
    pushDone(1'b1, 2);
    applyStimulus(1'b0);
    waitValid(50);
    reset = 1'b0;
    tick();
    checkOutput("midRstActValid", 32'(actValid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstProgress", 32'(progress), 32'd0);
    checkOutput("midRstPassCnt", 32'(passCnt), 32'd0);
    checkOutput("midRstActAddr", 32'(actAddr), 32'd0);
    checkOutput("midRstActFlag", 32'(actFlag), 32'd0);
    reset = 1'b1;
    expActQ.delete();
    expDoneQ.delete();
    actReady = 1'b1;
    tick();

    // Board cleared to hidden; a load while busy must not land.
    pushDone(1'b0, 1);
    applyStimulus(1'b0);
    tick();
    tick();
    ldEn   = 1'b1;
    ldAddr = '0;
    ldData = 4'h0;
    tick();
    ldEn   = 1'b0;
    waitDone(200, cycles);
    pushDone(1'b0, 1);
    applyStimulus(1'b0);
    waitDone(200, cycles);

    repeat (3) tick();
    checkOutput("finalPendingActions", 32'(expActQ.size()), 32'd0);
    checkOutput("finalPendingDone", 32'(expDoneQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
